// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - square-wave tone generator; optional articulation gap under ARTIC_GAP_EN
`timescale 1ns/1ps
module tone_synth #(
    parameter int CNT_W      = 20,
    parameter int GAP_CYCLES = 1000000,
    // Pitch table is divided by 2**DIV_SHIFT before octave scaling; 0 gives true audio pitch.
    parameter int DIV_SHIFT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] note,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing,
    output logic [2:0] cur_note,
    output logic [1:0] cur_oct
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
`ifdef ARTIC_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;
    logic             new_pitch;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] tbl_half;
    logic [CNT_W-1:0] base_half;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_m1;
    logic             toggle;
    logic             gap_end;
    logic             req_ok;
    logic             to_idle;

    always_comb begin
        tbl_half = '0;
        case (cur_note)
            3'd1:    tbl_half = CNT_W'(191113);
            3'd2:    tbl_half = CNT_W'(170262);
            3'd3:    tbl_half = CNT_W'(151686);
            3'd4:    tbl_half = CNT_W'(143173);
            3'd5:    tbl_half = CNT_W'(127551);
            3'd6:    tbl_half = CNT_W'(113636);
            3'd7:    tbl_half = CNT_W'(101239);
            default: tbl_half = '0;
        endcase
    end

    always_comb begin
        base_half = tbl_half >> DIV_SHIFT;
        case (cur_oct)
            2'b01:   half = base_half >> 1;
            2'b10:   half = base_half << 1;
            default: half = base_half;
        endcase
    end

    assign half_m1 = half - CNT_W'(1);
    assign toggle  = (state == ST_PLAY) && (counter == half_m1);
    assign req_ok  = en && (note != 3'd0);
    assign playing = (state != ST_IDLE);

`ifdef ARTIC_GAP_EN
    assign gap_end   = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign new_pitch = ({note, octave} != {cur_note, cur_oct});
`else
    assign gap_end   = 1'b0;
`endif

    // Mute wins over everything; a rest is only honoured on a phase boundary.
    assign to_idle = (state != ST_IDLE) && (!en || ((note == 3'd0) && (toggle || gap_end)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            counter  <= '0;
            speaker  <= 1'b0;
            cur_note <= 3'd0;
            cur_oct  <= 2'd0;
`ifdef ARTIC_GAP_EN
            gap_cnt  <= '0;
`endif
        end else if (to_idle) begin
            state    <= ST_IDLE;
            counter  <= '0;
            speaker  <= 1'b0;
            cur_note <= 3'd0;
            cur_oct  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        state    <= ST_PLAY;
                        cur_note <= note;
                        cur_oct  <= octave;
                        counter  <= '0;
                        speaker  <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (toggle) begin
                        counter  <= '0;
                        cur_note <= note;
                        cur_oct  <= octave;
`ifdef ARTIC_GAP_EN
                        if (new_pitch) begin
                            state   <= ST_GAP;
                            speaker <= 1'b0;
                            gap_cnt <= '0;
                        end else begin
                            speaker <= ~speaker;
                        end
`else
                        speaker  <= ~speaker;
`endif
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
`ifdef ARTIC_GAP_EN
                ST_GAP: begin
                    if (gap_end) begin
                        state   <= ST_PLAY;
                        counter <= '0;
                        speaker <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                    speaker <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - randomized self-checking bench for tone_synth against a countdown reference model
`timescale 1ns/1ps
module tb_tone_synth;

    localparam int SHIFT = 6;
    localparam int GAP   = 100;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       en, speaker, playing;
    logic [2:0] note, cur_note;
    logic [1:0] octave, cur_oct;

    logic       rst2_n = 1'b1;
    logic       en2, spk2, ply2;
    logic [2:0] note2, cn2;
    logic [1:0] oct2, co2;
    logic       done2 = 1'b0;

    tone_synth #(.CNT_W(20), .GAP_CYCLES(GAP), .DIV_SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .note(note), .octave(octave),
        .speaker(speaker), .playing(playing), .cur_note(cur_note), .cur_oct(cur_oct)
    );

    tone_synth #(.CNT_W(20)) dut_full (
        .clk(clk), .rst_n(rst2_n), .en(en2), .note(note2), .octave(oct2),
        .speaker(spk2), .playing(ply2), .cur_note(cn2), .cur_oct(co2)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int exp_half(input int nt, input int oc, input int sh);
        int t;
        case (nt)
            1: t = 191113;
            2: t = 170262;
            3: t = 151686;
            4: t = 143173;
            5: t = 127551;
            6: t = 113636;
            7: t = 101239;
            default: t = 0;
        endcase
        t = t / (1 << sh);
        if (oc == 1)      t = t / 2;
        else if (oc == 2) t = t * 2;
        return t;
    endfunction

    // Reference: a tone is a sequence of half-phases; count down the cycles left in each.
    logic       m_on = 1'b0, m_lvl = 1'b0;
    logic [2:0] m_note = 3'd0;
    logic [1:0] m_oct = 2'd0;
    int         m_left = 0, m_gap = 0;

    task automatic model_clear();
        m_on = 1'b0; m_lvl = 1'b0; m_note = 3'd0; m_oct = 2'd0; m_left = 0; m_gap = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else if (m_on && !en) begin
            model_clear();
        end else if (!m_on) begin
            if (en && note != 3'd0) begin
                m_on = 1'b1; m_note = note; m_oct = octave; m_lvl = 1'b1;
                m_left = exp_half(note, octave, SHIFT); m_gap = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                if (note == 3'd0) model_clear();
                else begin m_lvl = 1'b1; m_left = exp_half(m_note, m_oct, SHIFT); end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (note == 3'd0) model_clear();
`ifdef ARTIC_GAP_EN
                else if ({note, octave} != {m_note, m_oct}) begin
                    m_note = note; m_oct = octave; m_lvl = 1'b0; m_gap = GAP;
                end
`endif
                else begin
                    m_note = note; m_oct = octave; m_lvl = ~m_lvl;
                    m_left = exp_half(note, octave, SHIFT);
                end
            end
        end
    end

    logic [6:0] prev_d = '0, prev_m = '0;
    always @(negedge clk) begin
        logic [6:0] d, m;
        d = {speaker, playing, cur_note, cur_oct};
        m = {m_lvl, m_on, m_note, m_oct};
        if (d !== prev_d || m !== prev_m) check("model", {25'd0, d}, {25'd0, m});
        prev_d = d;
        prev_m = m;
    end

    task automatic drive(input logic e, input logic [2:0] n, input logic [1:0] o);
        en = e; note = n; octave = o;
    endtask

    task automatic wait_rise();
        logic prev;
        int w;
        prev = speaker;
        w = 0;
        while (w < LIMIT) begin
            @(negedge clk);
            w++;
            if (!prev && speaker) break;
            prev = speaker;
        end
        check("rise_seen", {31'd0, (!prev && speaker)}, 32'd1);
    endtask

    task automatic count_phase(input logic lvl, input int chg_at, input logic [2:0] cn,
                               input logic [1:0] co, output int n);
        n = 1;
        while (n < LIMIT) begin
            if (n == chg_at) drive(1'b1, cn, co);
            @(negedge clk);
            if (speaker != lvl) break;
            n++;
        end
    endtask

    initial begin : full_scale
        int n;
        en2 = 1'b0; note2 = 3'd0; oct2 = 2'd0;
        #2 rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        en2 = 1'b1; note2 = 3'd7; oct2 = 2'b01;
        @(negedge clk);
        check("full_latency", {31'd0, spk2}, 32'd1);
        n = 1;
        while (n < 60000) begin
            @(negedge clk);
            if (!spk2) break;
            n++;
        end
        check("full_si_high", n, exp_half(7, 1, 0));
        en2 = 1'b0;
        @(negedge clk);
        check("full_mute", {29'd0, spk2, ply2, cn2 != 3'd0 || co2 != 2'd0}, 32'd0);
        done2 = 1'b1;
    end

    initial begin : main
        int n, w;
        drive(1'b0, 3'd0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_speaker", {31'd0, speaker}, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_cur_note", {29'd0, cur_note}, 32'd0);
        check("rst_cur_oct", {30'd0, cur_oct}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        drive(1'b1, 3'd1, 2'b00);
        @(negedge clk);
        check("lat_speaker", {31'd0, speaker}, 32'd1);
        check("lat_playing", {31'd0, playing}, 32'd1);
        check("lat_cur_note", {29'd0, cur_note}, 32'd1);
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("do_mid_high", n, exp_half(1, 0, SHIFT));

        drive(1'b1, 3'd6, 2'b01);
        wait_rise();
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("la_high_high", n, exp_half(6, 1, SHIFT));

        drive(1'b1, 3'd7, 2'b10);
        wait_rise();
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("si_low_high", n, exp_half(7, 2, SHIFT));

        drive(1'b1, 3'd7, 2'b11);
        wait_rise();
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("oct11_as_mid", n, exp_half(7, 0, SHIFT));

        drive(1'b1, 3'd1, 2'b00);
        wait_rise();
        count_phase(1'b1, 500, 3'd2, 2'b00, n);
        check("held_phase", n, exp_half(1, 0, SHIFT));
`ifdef ARTIC_GAP_EN
        count_phase(1'b0, 0, 3'd0, 2'd0, n);
        check("gap_len", n, GAP);
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("re_after_gap", n, exp_half(2, 0, SHIFT));
        count_phase(1'b0, 0, 3'd0, 2'd0, n);
        check("re_no_gap", n, exp_half(2, 0, SHIFT));
`else
        count_phase(1'b0, 0, 3'd0, 2'd0, n);
        check("re_low", n, exp_half(2, 0, SHIFT));
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("re_high", n, exp_half(2, 0, SHIFT));
`endif

        drive(1'b1, 3'd4, 2'b01);
        wait_rise();
        repeat (300) @(negedge clk);
        drive(1'b1, 3'd0, 2'b01);
        w = 0;
        while (playing && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        check("rest_delay", w, exp_half(4, 1, SHIFT) - 300);
        check("rest_outputs", {26'd0, speaker, cur_note, cur_oct}, 32'd0);

        drive(1'b1, 3'd5, 2'b10);
        wait_rise();
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("mute_now", {27'd0, speaker, playing, cur_note}, 32'd0);

        drive(1'b1, 3'd5, 2'b00);
        wait_rise();
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_speaker", {31'd0, speaker}, 32'd0);
        check("rst_mid_playing", {31'd0, playing}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 2'b00);
        wait_rise();
        count_phase(1'b1, 0, 3'd0, 2'd0, n);
        check("mi_after_rst", n, exp_half(3, 0, SHIFT));

        for (int s = 0; s < 12; s++) begin
            drive($urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(100, 2500)) @(negedge clk);
        end
        drive(1'b0, 3'd0, 2'd0);
        repeat (2) @(negedge clk);
        check("final_idle", {31'd0, playing}, 32'd0);

        w = 0;
        while (!done2 && w < 70000) begin
            @(negedge clk);
            w++;
        end
        check("full_done", {31'd0, done2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
